// File: rtl/trace_pkg.sv
// Shared definitions for the scope trace path: screen geometry, acquisition
// FSM encoding (also decoded by the drawer's status logic) and row scaling.
package trace_pkg;

   localparam int NPOINTS  = 160;
   localparam int SCREEN_H = 120;
   localparam int ROW_MAX  = SCREEN_H - 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOW  = 3'd1,
      ST_WAIT_RISE = 3'd2,
      ST_CAPTURE   = 3'd3,
      ST_READY     = 3'd4
   } state_t;

   // 7-bit sample code to screen row; full-scale input lands on the top row.
   function automatic logic [7:0] scale_row(input logic [6:0] s);
      logic [10:0] prod;
      prod = {4'd0, s} * 11'd15;
      return 8'(ROW_MAX) - {1'b0, prod[10:4]};
   endfunction

endpackage

// File: rtl/trace_capture_if.sv
// ADC sample stream and drawer read/handoff bus of the trace capture block.
interface trace_capture_if #(
   parameter int SAMPLE_W = 14
) ();
   logic                adc_valid;
   logic [SAMPLE_W-1:0] adc_data;
   logic [7:0]          rd_addr;
   logic [7:0]          rd_data;
   logic                frame_ready;
   logic                draw_done;

   modport slave (
      input  adc_valid, adc_data, rd_addr, draw_done,
      output rd_data, frame_ready
   );

   modport master (
      output adc_valid, adc_data, rd_addr, draw_done,
      input  rd_data, frame_ready
   );
endinterface

// File: rtl/trace_ram.sv
// Trace buffer: simple dual-port RAM, one synchronous write port and one
// registered read port; out-of-range reads return 0.
module trace_ram #(
   parameter int DEPTH = trace_pkg::NPOINTS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data
);
   logic [7:0] mem_r [DEPTH];

   // Write port; the array has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we && (wr_addr < 8'(DEPTH))) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= 8'd0;
      end else if (rd_addr < 8'(DEPTH)) begin
         rd_data <= mem_r[rd_addr];
      end else begin
         rd_data <= 8'd0;
      end
   end
endmodule

// File: rtl/trace_capture.sv
// Acquisition side of the scope trace path: rising-edge trigger with auto
// timeout, decimation, row scaling and frame handoff to the trace drawer.
module trace_capture #(
   parameter int SAMPLE_W = 14,
   parameter int NPOINTS  = trace_pkg::NPOINTS,
   parameter int TIMEOUT  = 4096
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [SAMPLE_W-1:0] trig_level,
   input  logic [7:0]          decim,
   output logic                capturing,
   output logic                auto_trig,
   trace_capture_if.slave      bus
);
   import trace_pkg::*;

   localparam int               TMO_W     = $clog2(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [7:0]       ADDR_LAST = 8'(NPOINTS - 1);

   state_t            state_r, state_s;
   logic [7:0]        wr_addr_r, wr_addr_s;
   logic [7:0]        dec_r, dec_s;
   logic [TMO_W-1:0]  tmo_r, tmo_s;
   logic              auto_r, auto_s;
   logic              frame_ready_r, capturing_r;
   logic              trig_s, we_s;
   logic [7:0]        wa_s, row_s;

   assign row_s = scale_row(bus.adc_data[SAMPLE_W-1 -: 7]);

   // Next-state, counter and write-port decode.
   always_comb begin
      state_s   = state_r;
      wr_addr_s = wr_addr_r;
      dec_s     = dec_r;
      tmo_s     = tmo_r;
      auto_s    = auto_r;
      trig_s    = 1'b0;
      we_s      = 1'b0;
      wa_s      = wr_addr_r;
      case (state_r)
         ST_IDLE: begin
            tmo_s  = {TMO_W{1'b0}};
            auto_s = 1'b0;
            if (run) begin
               state_s = ST_WAIT_LOW;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT_LOW, ST_WAIT_RISE: begin
            if (bus.adc_valid) begin
               // A genuine crossing on the timeout sample wins over the forced trigger.
               if ((state_r == ST_WAIT_RISE) && (bus.adc_data >= trig_level)) begin
                  trig_s = 1'b1;
               end else if (tmo_r == TMO_LAST) begin
                  trig_s = 1'b1;
                  auto_s = 1'b1;
               end else begin
                  tmo_s = tmo_r + TMO_W'(1);
                  if ((state_r == ST_WAIT_LOW) && (bus.adc_data < trig_level)) begin
                     state_s = ST_WAIT_RISE;
                  end else begin
                     state_s = state_r;
                  end
               end
               if (trig_s) begin
                  we_s      = 1'b1;
                  wa_s      = 8'd0;
                  wr_addr_s = 8'd1;
                  dec_s     = decim;
                  tmo_s     = {TMO_W{1'b0}};
                  state_s   = ST_CAPTURE;
               end else begin
                  we_s = 1'b0;
               end
            end else begin
               state_s = state_r;
            end
         end
         ST_CAPTURE: begin
            if (bus.adc_valid) begin
               if (dec_r == 8'd0) begin
                  we_s      = 1'b1;
                  wa_s      = wr_addr_r;
                  wr_addr_s = wr_addr_r + 8'd1;
                  dec_s     = decim;
                  if (wr_addr_r == ADDR_LAST) begin
                     state_s = ST_READY;
                  end else begin
                     state_s = ST_CAPTURE;
                  end
               end else begin
                  dec_s = dec_r - 8'd1;
               end
            end else begin
               dec_s = dec_r;
            end
         end
         ST_READY: begin
            if (bus.draw_done) begin
               auto_s = 1'b0;
               if (run) begin
                  state_s = ST_WAIT_LOW;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_READY;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         wr_addr_r     <= 8'd0;
         dec_r         <= 8'd0;
         tmo_r         <= {TMO_W{1'b0}};
         auto_r        <= 1'b0;
         frame_ready_r <= 1'b0;
         capturing_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         wr_addr_r     <= wr_addr_s;
         dec_r         <= dec_s;
         tmo_r         <= tmo_s;
         auto_r        <= auto_s;
         frame_ready_r <= (state_s == ST_READY);
         capturing_r   <= (state_s == ST_CAPTURE);
      end
   end

   assign capturing       = capturing_r;
   assign auto_trig       = auto_r;
   assign bus.frame_ready = frame_ready_r;

   trace_ram #(
      .DEPTH (NPOINTS)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (we_s),
      .wr_addr (wa_s),
      .wr_data (row_s),
      .rd_addr (bus.rd_addr),
      .rd_data (bus.rd_data)
   );
endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture: trigger, timeout, decimation,
// handoff, read latency and mid-capture reset.
module tb_trace_capture;
   localparam int SW = 14;

   logic          clk = 1'b0;
   logic          reset;
   logic          run;
   logic [SW-1:0] trig_level;
   logic [7:0]    decim;
   logic          capturing;
   logic          auto_trig;

   int total = 0;
   int bad   = 0;
   int exp_mem [160];

   trace_capture_if #(.SAMPLE_W(SW)) bus ();

   trace_capture #(
      .SAMPLE_W (SW),
      .NPOINTS  (160),
      .TIMEOUT  (4096)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .trig_level (trig_level),
      .decim      (decim),
      .capturing  (capturing),
      .auto_trig  (auto_trig),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference scaling: top 7 bits of the 14-bit sample.
   function automatic int row_of(input int d);
      int s;
      s = (d >> 7) & 127;
      return 119 - (s * 15) / 16;
   endfunction

   task automatic valid(input int d);
      bus.adc_valid = 1'b1;
      bus.adc_data  = 14'(d);
      tick();
      bus.adc_valid = 1'b0;
   endtask

   task automatic pulse_done();
      bus.draw_done = 1'b1;
      tick();
      bus.draw_done = 1'b0;
   endtask

   task automatic rd(input int a, output int v);
      bus.rd_addr = 8'(a);
      tick();
      v = bus.rd_data;
   endtask

   task automatic read_all(input string tag);
      for (int k = 0; k < 160; k++) begin
         bus.rd_addr = 8'(k);
         tick();
         chk($sformatf("%s[%0d]", tag, k), bus.rd_data, exp_mem[k]);
      end
   endtask

   // Feed a constant or ramp after the trigger until frame_ready; n counts valids incl. trigger.
   task automatic fill(input int base, input int step, output int n);
      n = 1;
      while (!bus.frame_ready && n < 1000) begin
         valid(base + n * step);
         n++;
      end
   endtask

   initial begin
      int n;
      int v;
      int hit;

      reset         = 1'b1;
      run           = 1'b0;
      trig_level    = 14'd0;
      decim         = 8'd0;
      bus.adc_valid = 1'b0;
      bus.adc_data  = 14'd0;
      bus.rd_addr   = 8'd0;
      bus.draw_done = 1'b0;
      repeat (3) tick();
      chk("rst_frame_ready", bus.frame_ready, 0);
      chk("rst_capturing", capturing, 0);
      chk("rst_auto_trig", auto_trig, 0);
      chk("rst_rd_data", bus.rd_data, 0);

      // Ramp trigger at 0x2000, step 0x40 per valid.
      reset      = 1'b0;
      run        = 1'b1;
      trig_level = 14'h2000;
      tick();
      n = 0;
      while (!bus.frame_ready && n < 1000) begin
         valid((n * 64) & 32'h3fff);
         n++;
      end
      chk("ramp_valids", n, 288);
      chk("ramp_auto", auto_trig, 0);
      chk("ramp_capt_off", capturing, 0);
      rd(0, v);
      chk("ramp_entry0", v, 59);
      bus.rd_addr = 8'd159;
      chk("rd_latency_hold", bus.rd_data, 59);
      tick();
      chk("ramp_entry159", bus.rd_data, 105);
      for (int k = 0; k < 160; k++) exp_mem[k] = row_of(32'h2000 + k * 64);
      read_all("ramp");
      rd(200, v);
      chk("rd_out_of_range", v, 0);

      // Handoff with run=1, then no crossing: forced trigger on valid #4096.
      pulse_done();
      chk("handoff_fr_fall", bus.frame_ready, 0);
      trig_level = 14'h3000;
      for (int i = 0; i < 4095; i++) valid(32'h1000);
      chk("tmo_not_yet", capturing, 0);
      valid(32'h1000);
      chk("tmo_capturing", capturing, 1);
      chk("tmo_auto", auto_trig, 1);
      fill(32'h1000, 0, n);
      chk("tmo_valids", n, 160);
      chk("tmo_auto_ready", auto_trig, 1);
      for (int k = 0; k < 160; k++) exp_mem[k] = 89;
      read_all("tmo");

      // Decimation by 4 on a unit ramp after the trigger.
      pulse_done();
      chk("auto_cleared", auto_trig, 0);
      decim      = 8'd3;
      trig_level = 14'h2000;
      valid(32'h0100);
      valid(32'h2000);
      chk("dec_capturing", capturing, 1);
      fill(32'h2000, 1, n);
      chk("dec_valids", n, 637);
      rd(159, v);
      chk("dec_entry159", v, 56);
      for (int k = 0; k < 160; k++) exp_mem[k] = row_of(32'h2000 + 4 * k);
      read_all("dec");

      // Handoff with run=0: back to IDLE, samples ignored.
      run = 1'b0;
      pulse_done();
      chk("stop_fr_fall", bus.frame_ready, 0);
      hit = 0;
      for (int i = 0; i < 300; i++) begin
         valid(((i % 2) == 1) ? 32'h3fff : 32'h0000);
         hit = hit | int'(capturing) | int'(bus.frame_ready);
      end
      chk("idle_no_capture", hit, 0);
      rd(0, v);
      chk("idle_entry0_kept", v, 59);
      rd(159, v);
      chk("idle_entry159_kept", v, 56);

      // Reset at write address 80, then a clean restart.
      run   = 1'b1;
      decim = 8'd0;
      tick();
      valid(32'h0000);
      valid(32'h3f80);
      for (int i = 0; i < 79; i++) valid(32'h3f80);
      chk("pre_reset_capt", capturing, 1);
      reset = 1'b1;
      tick();
      chk("mid_rst_fr", bus.frame_ready, 0);
      chk("mid_rst_capt", capturing, 0);
      chk("mid_rst_auto", auto_trig, 0);
      chk("mid_rst_rd", bus.rd_data, 0);
      reset = 1'b0;
      tick();
      valid(32'h0000);
      valid(32'h2000);
      fill(32'h0000, 0, n);
      chk("restart_valids", n, 160);
      exp_mem[0] = 59;
      for (int k = 1; k < 160; k++) exp_mem[k] = 119;
      read_all("restart");

      // Real crossing exactly on the timeout sample: no auto trigger.
      pulse_done();
      trig_level = 14'h3000;
      for (int i = 0; i < 4095; i++) valid(32'h1000);
      valid(32'h3000);
      chk("tie_capturing", capturing, 1);
      chk("tie_auto", auto_trig, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
